// File: rtl/h75_frame_buffer.sv
// Dual-bank RGB888 frame buffer feeding the HUB75 timing generator.
// The writer fills the back bank; the front bank is read and sliced into one bit-plane per read.
module h75_frame_buffer #(
    parameter int ADDR_W  = 14,
    parameter int COLOR_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [6*COLOR_W-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 front_bank,
    input  logic                 frame_sync,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [2:0]           plane,
    input  logic                 display_en,
    output logic [5:0]           rgb_out,
    output logic [1:0]           dbg_state
);
    localparam int WORD_W = 6 * COLOR_W;
    localparam int DEPTH  = 2 ** (ADDR_W + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_SWAP    = 2'd2
    } swap_state_t;

    swap_state_t       state, state_nxt;
    logic              frame_sync_q;
    logic              fs_rise;
    logic              wr_fire;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_word;
    logic [2:0]        plane_q;
    logic              display_en_q;
    logic [5:0]        plane_bits;
    logic [COLOR_W-1:0] chan;

    assign fs_rise   = frame_sync & ~frame_sync_q;
    assign dbg_state = state;

    // Write handshake: a word is taken on any cycle where wr_en and wr_ready are both
    // high; wr_en while wr_ready is low is simply dropped, the writer must retry.
    assign wr_fire = wr_en & wr_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            frame_sync_q <= 1'b0;
            front_bank   <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_sync_q <= frame_sync;
            if (state == S_SWAP)
                front_bank <= ~front_bank;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        swap_ack  = 1'b0;
        case (state)
            S_IDLE: begin
                wr_ready = 1'b1;
                if (swap_req)
                    state_nxt = S_PENDING;
            end
            S_PENDING: begin
                if (fs_rise)
                    state_nxt = S_SWAP;
            end
            S_SWAP: begin
                swap_ack  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Both banks share one array; the bank bit is the address MSB.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[{~front_bank, wr_addr}] <= wr_data;
        rd_word <= mem[{front_bank, rd_addr}];
    end

    always_comb begin
        plane_bits = '0;
        chan       = '0;
        for (int j = 0; j < 6; j++) begin
            chan          = rd_word[j*COLOR_W +: COLOR_W];
            plane_bits[j] = chan[plane_q];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plane_q      <= 3'd0;
            display_en_q <= 1'b0;
            rgb_out      <= 6'd0;
        end else begin
            plane_q      <= plane;
            display_en_q <= display_en;
            rgb_out      <= plane_bits & {6{display_en_q}};
        end
    end

endmodule
